// File: rtl/ws2812_frame_feeder.sv
// rtl/ws2812_frame_feeder.sv - double-buffered pixel store feeding one scaled 24-bit word per LED to the WS2812 RZ encoder
// Prefetch runs READ -> SCALE -> VALID after every load so the next word is ready long before the next tx_done.
module ws2812_frame_feeder #(
   parameter int LED_NUM = 8,
   parameter int ADDR_W  = 8,
   parameter bit GRB     = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [23:0]       wr_data,
   input  logic              swap_req,
   input  logic [7:0]        bright,
   input  logic              tx_done,
   output logic              data_ready,
   output logic [23:0]       RGB,
   output logic              data_end,
   output logic              frame_done,
   output logic              swap_ack
);
   localparam int IDX_W = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
   localparam int MEM_D = (LED_NUM > 1) ? LED_NUM : 2;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(LED_NUM - 1);

   localparam logic [1:0] PF_IDLE  = 2'd0;
   localparam logic [1:0] PF_READ  = 2'd1;
   localparam logic [1:0] PF_SCALE = 2'd2;
   localparam logic [1:0] PF_VALID = 2'd3;

   logic [23:0]      mem0 [0:MEM_D-1];
   logic [23:0]      mem1 [0:MEM_D-1];
   logic [23:0]      rd_q;
   logic [1:0]       pf_state;
   logic [IDX_W-1:0] idx;
   logic [23:0]      pf_reg;
   logic             rd_bank;
   logic             swap_pend;
   logic             first_frame;
   logic [7:0]       bright_lat;

   logic             wr_ok;
   logic [IDX_W-1:0] wr_idx;
   logic             start;
   logic             load;
   logic             boundary;
   logic [8:0]       gain;
   logic [7:0]       r_s, g_s, b_s;
   logic [23:0]      scaled;

   function automatic logic [7:0] scale(input logic [7:0] c, input logic [8:0] k);
      return 8'(({8'd0, c} * {7'd0, k}) >> 8);
   endfunction

   assign wr_ok  = wr_en && ({1'b0, wr_addr} < (ADDR_W+1)'(LED_NUM));
   assign wr_idx = wr_addr[IDX_W-1:0];

   // start: first cycle of enable; boundary: LED 0 of the coming frame is about to be fetched
   assign start    = enable && !data_ready;
   assign load     = enable && data_ready && tx_done;
   assign boundary = start || (load && (idx == LAST));

   assign gain   = {1'b0, bright_lat} + 9'd1;
   assign r_s    = scale(rd_q[23:16], gain);
   assign g_s    = scale(rd_q[15:8], gain);
   assign b_s    = scale(rd_q[7:0], gain);
   assign scaled = GRB ? {g_s, r_s, b_s} : {r_s, g_s, b_s};

   // host always writes the bank not being displayed, so reads and writes never collide
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         if (rd_bank) mem0[wr_idx] <= wr_data;
         else         mem1[wr_idx] <= wr_data;
      end
      if (pf_state == PF_READ)
         rd_q <= rd_bank ? mem1[idx] : mem0[idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_ready  <= 1'b0;
         RGB         <= '0;
         data_end    <= 1'b0;
         frame_done  <= 1'b0;
         swap_ack    <= 1'b0;
         rd_bank     <= 1'b0;
         swap_pend   <= 1'b0;
         idx         <= '0;
         pf_reg      <= '0;
         pf_state    <= PF_IDLE;
         first_frame <= 1'b1;
         bright_lat  <= '0;
      end else begin
         data_ready <= enable;
         frame_done <= 1'b0;
         swap_ack   <= 1'b0;
         if (swap_req)
            swap_pend <= 1'b1;
         if (!enable) begin
            idx         <= '0;
            pf_reg      <= '0;
            pf_state    <= PF_IDLE;
            first_frame <= 1'b1;
            RGB         <= '0;
            data_end    <= 1'b0;
         end else begin
            if (load) begin
               RGB        <= pf_reg;
               data_end   <= (idx == LAST);
               frame_done <= (idx == '0) && !first_frame;
               if (idx == '0)
                  first_frame <= 1'b0;
               idx <= (idx == LAST) ? '0 : idx + 1'b1;
            end
            if (start || load) begin
               pf_state <= PF_READ;
            end else begin
               case (pf_state)
                  PF_READ:  pf_state <= PF_SCALE;
                  PF_SCALE: begin
                     pf_reg   <= scaled;
                     pf_state <= PF_VALID;
                  end
                  default:  pf_state <= pf_state;
               endcase
            end
            // bank and brightness are frozen for the whole frame from here
            if (boundary) begin
               bright_lat <= bright;
               if (swap_pend) begin
                  rd_bank   <= ~rd_bank;
                  swap_pend <= 1'b0;
                  swap_ack  <= 1'b1;
               end
            end
         end
      end
   end
endmodule
